// File: rtl/loader_pkg.sv
// Shared definitions for the instruction-memory loader.
//   state_t        : loader session states
//   LEN_BYTES      : header length field size in bytes (little-endian N)
//   BYTES_PER_WORD : payload bytes assembled into one instruction word
//   CSUM_W         : width of the wrap-around payload checksum
//   csum_add       : modulo-2^CSUM_W accumulate of one payload byte
package loader_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LEN0 = 3'd1,
    LEN1 = 3'd2,
    DATA = 3'd3,
    CSUM = 3'd4,
    ERR  = 3'd5
  } state_t;

  localparam int LEN_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;
  localparam int CSUM_W         = 8;

  // The sum simply wraps; carries out of the top bit are discarded.
  function automatic logic [CSUM_W-1:0] csum_add(input logic [CSUM_W-1:0] sum,
                                                 input logic [7:0]        data);
    return sum + CSUM_W'(data);
  endfunction

endpackage

// File: rtl/word_assembler.sv
// Little-endian byte-to-word assembler.
// Collects BYTES_PER_WORD bytes into lanes (first byte -> bits 7:0). The last
// byte is not stored: it is forwarded straight into the top lane of 'word' so
// the complete word is available in the same cycle the final byte is taken.
// Ports:
//   clk, reset  : clock and synchronous active-high reset
//   clear       : restart lane counting (new session)
//   byte_en     : consume byte_data this cycle
//   byte_data   : incoming byte
//   word_ready  : high in the cycle the final byte of a word is consumed
//   word        : assembled word, valid while word_ready is high
module word_assembler
  import loader_pkg::*;
(
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        clear,
  input  logic                        byte_en,
  input  logic [7:0]                  byte_data,
  output logic                        word_ready,
  output logic [8*BYTES_PER_WORD-1:0] word
);

  localparam int CNT_W = $clog2(BYTES_PER_WORD);

  logic [CNT_W-1:0] cnt_reg;
  logic [7:0]       lane_reg [BYTES_PER_WORD-1];

  // Counter wraps naturally from the last lane back to lane 0.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt_reg <= '0;
    end else if (byte_en) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < BYTES_PER_WORD - 1; gi++) begin : g_lane
      always_ff @(posedge clk) begin
        if (reset || clear) begin
          lane_reg[gi] <= '0;
        end else if (byte_en && (cnt_reg == CNT_W'(gi))) begin
          lane_reg[gi] <= byte_data;
        end
      end
      assign word[gi*8 +: 8] = lane_reg[gi];
    end
  endgenerate

  assign word[8*BYTES_PER_WORD-1 -: 8] = byte_data;
  assign word_ready = byte_en && (cnt_reg == CNT_W'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory loader: writer side of the core's instruction memory.
// Accepts a framed byte stream {N lo, N hi, 4*N payload bytes, checksum},
// writes each little-endian word to consecutive addresses from 0, and keeps
// the core held in reset for the whole session. A bad length or checksum
// leaves the core held with error raised until the next start.
// Ports:
//   clk, reset          : clock and synchronous active-high reset
//   start               : single-cycle session request (IDLE/ERR only)
//   byte_valid/byte_data: input byte stream
//   byte_ready          : a byte is accepted when byte_valid && byte_ready
//   wr_en/wr_addr/wr_data: instruction-memory write port (registered)
//   core_hold           : keeps the core in reset
//   busy                : session in progress
//   done                : one-cycle success pulse
//   error               : failure flag, held until the next start
module imem_loader
  import loader_pkg::*;
#(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              core_hold,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam int LEN_W = 8 * LEN_BYTES;

  state_t             state_reg, state_next;
  logic [LEN_W-1:0]   len_reg;
  logic [ADDR_W-1:0]  word_idx_reg;
  logic [CSUM_W-1:0]  sum_reg;
  logic               wr_en_reg;
  logic [ADDR_W-1:0]  wr_addr_reg;
  logic [31:0]        wr_data_reg;
  logic               done_reg;

  logic               accept;
  logic               start_ok;
  logic               payload_en;
  logic               word_ready;
  logic [31:0]        word;
  logic [LEN_W-1:0]   len_full;
  logic               len_bad;
  logic               last_word;
  logic               csum_match;

  assign byte_ready = (state_reg == LEN0) || (state_reg == LEN1) ||
                      (state_reg == DATA) || (state_reg == CSUM);
  assign accept     = byte_valid && byte_ready;
  assign start_ok   = start && ((state_reg == IDLE) || (state_reg == ERR));
  assign payload_en = accept && (state_reg == DATA);

  // Length as it will be once the high byte currently on the bus is latched.
  assign len_full   = {byte_data, len_reg[7:0]};
  assign len_bad    = (len_full == '0) || (len_full > LEN_W'(DEPTH));
  assign last_word  = (LEN_W'(word_idx_reg) == (len_reg - 1'b1));
  assign csum_match = (byte_data == sum_reg);

  word_assembler u_word_assembler (
    .clk        (clk),
    .reset      (reset),
    .clear      (start_ok),
    .byte_en    (payload_en),
    .byte_data  (byte_data),
    .word_ready (word_ready),
    .word       (word)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE, ERR: if (start)  state_next = LEN0;
      LEN0:      if (accept) state_next = LEN1;
      LEN1:      if (accept) state_next = len_bad ? ERR : DATA;
      DATA:      if (word_ready && last_word) state_next = CSUM;
      CSUM:      if (accept) state_next = csum_match ? IDLE : ERR;
      default:   state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      len_reg      <= '0;
      word_idx_reg <= '0;
      sum_reg      <= '0;
      wr_en_reg    <= 1'b0;
      wr_addr_reg  <= '0;
      wr_data_reg  <= '0;
      done_reg     <= 1'b0;
    end else begin
      state_reg <= state_next;
      wr_en_reg <= word_ready;
      done_reg  <= (state_reg == CSUM) && accept && csum_match;

      if (start_ok) begin
        word_idx_reg <= '0;
        sum_reg      <= '0;
      end

      if (accept && (state_reg == LEN0)) len_reg[7:0]       <= byte_data;
      if (accept && (state_reg == LEN1)) len_reg[LEN_W-1:8] <= byte_data;

      if (payload_en) sum_reg <= csum_add(sum_reg, byte_data);

      // Address/data only move on a write so they hold between strobes.
      if (word_ready) begin
        wr_addr_reg  <= word_idx_reg;
        wr_data_reg  <= word;
        word_idx_reg <= word_idx_reg + 1'b1;
      end
    end
  end

  assign wr_en     = wr_en_reg;
  assign wr_addr   = wr_addr_reg;
  assign wr_data   = wr_data_reg;
  assign done      = done_reg;
  assign busy      = byte_ready;
  assign core_hold = (state_reg != IDLE);
  assign error     = (state_reg == ERR);

endmodule
